product_accumulator: RTL and testbench

- Sequential stage directly downstream of the 3-bit multiplier.
- Accepts a stream of 6-bit products over a valid/ready handshake and sums up to TERMS products per group (dot-product style).
- Presents each group's saturated sum, term count and overflow flag on a valid/ready output port.
- A group closes on the TERMS-th product or on an early in_last.

---
 rtl/product_accumulator.sv | 97 +++++++++
 tb/tb_product_accumulator.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// Accumulates a stream of unsigned multiplier products into saturating group sums
// and hands each group's sum, term count and overflow flag to a valid/ready consumer.
module product_accumulator #(
    parameter int PROD_W = 6,
    parameter int ACC_W  = 8,
    parameter int TERMS  = 4,
    parameter int CNT_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    typedef enum logic {ACCUM, DONE} state_t;

    typedef struct packed {
        logic [ACC_W-1:0] sum;
        logic [CNT_W-1:0] count;
        logic             ovf;
    } result_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf_flag;

    logic             accept;
    logic             close;
    logic [ACC_W:0]   prod_ext;
    logic [ACC_W:0]   sum_wide;
    result_t          nxt;

    assign in_ready = (state == ACCUM) && !rst;
    assign accept   = in_valid && in_ready;

    // One guard bit above the accumulator catches the carry-out that triggers saturation;
    // a saturated accumulator stays all-ones because any further nonzero add carries again.
    assign prod_ext = {{(ACC_W + 1 - PROD_W){1'b0}}, in_prod};
    assign sum_wide = {1'b0, acc} + prod_ext;

    always_comb begin
        nxt.sum   = sum_wide[ACC_W] ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
        nxt.count = cnt + CNT_W'(1);
        nxt.ovf   = ovf_flag | sum_wide[ACC_W];
    end

    assign close = accept && ((nxt.count == CNT_W'(TERMS)) || in_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            ovf_flag  <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (close) begin
                        out_sum   <= nxt.sum;
                        out_count <= nxt.count;
                        out_ovf   <= nxt.ovf;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (accept) begin
                        acc      <= nxt.sum;
                        cnt      <= nxt.count;
                        ovf_flag <= nxt.ovf;
                    end
                end
                DONE: begin
                    // Result registers keep their values after the handshake; only the group state clears.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        acc       <= '0;
                        cnt       <= '0;
                        ovf_flag  <= 1'b0;
                        state     <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench: two instances (8-bit and 7-bit accumulators) share one input stream;
// a group-level model predicts each result and a monitor checks them at the output handshake.
module tb_product_accumulator;

    localparam int TERMS = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [5:0] in_prod;
    logic       in_last;
    logic       out_ready;

    logic       in_ready_a, out_valid_a, out_ovf_a;
    logic [7:0] out_sum_a;
    logic [2:0] out_count_a;
    logic       in_ready_b, out_valid_b, out_ovf_b;
    logic [6:0] out_sum_b;
    logic [2:0] out_count_b;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int sum;
        int cnt;
        int ovf;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   grp[$];

    always #5 clk = ~clk;

    product_accumulator #(.PROD_W(6), .ACC_W(8), .TERMS(TERMS), .CNT_W(3)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .in_prod(in_prod),
        .in_last(in_last), .out_valid(out_valid_a), .out_ready(out_ready), .out_sum(out_sum_a),
        .out_count(out_count_a), .out_ovf(out_ovf_a)
    );

    product_accumulator #(.PROD_W(6), .ACC_W(7), .TERMS(TERMS), .CNT_W(3)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .in_prod(in_prod),
        .in_last(in_last), .out_valid(out_valid_b), .out_ready(out_ready), .out_sum(out_sum_b),
        .out_count(out_count_b), .out_ovf(out_ovf_b)
    );

    function automatic void check(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Group model: saturated sum is min(total, max); overflow iff the true total exceeds max.
    function automatic void close_group();
        int s;
        exp_t e;
        s = 0;
        foreach (grp[i]) s += grp[i];
        e.cnt = grp.size();
        e.sum = (s > 255) ? 255 : s;
        e.ovf = (s > 255) ? 1 : 0;
        q_a.push_back(e);
        e.sum = (s > 127) ? 127 : s;
        e.ovf = (s > 127) ? 1 : 0;
        q_b.push_back(e);
        grp.delete();
    endfunction

    task automatic send(input int prod, input bit last);
        int n;
        in_valid = 1'b1;
        in_prod  = 6'(prod);
        in_last  = last;
        #1;
        n = 0;
        while (!in_ready_a && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("in_ready_agree", int'(in_ready_b), int'(in_ready_a));
        if (!in_ready_a) begin
            check("send_timeout", 0, 1);
        end else begin
            grp.push_back(prod);
            if (last || grp.size() == TERMS) close_group();
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        grp.delete();
        q_a.delete();
        q_b.delete();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", q_a.size() + q_b.size(), 0);
    endtask

    always @(negedge clk) begin
        #3;
        if (!rst && out_ready) begin
            if (out_valid_a) begin
                if (q_a.size() == 0) check("unexpected_out_a", 1, 0);
                else begin
                    exp_t e;
                    e = q_a.pop_front();
                    check("sum_a", int'(out_sum_a), e.sum);
                    check("count_a", int'(out_count_a), e.cnt);
                    check("ovf_a", int'(out_ovf_a), e.ovf);
                end
            end
            if (out_valid_b) begin
                if (q_b.size() == 0) check("unexpected_out_b", 1, 0);
                else begin
                    exp_t e;
                    e = q_b.pop_front();
                    check("sum_b", int'(out_sum_b), e.sum);
                    check("count_b", int'(out_count_b), e.cnt);
                    check("ovf_b", int'(out_ovf_b), e.ovf);
                end
            end
        end
    end

    initial begin
        int lows;
        int snap;
        rst = 1'b1; in_valid = 1'b0; in_prod = '0; in_last = 1'b0; out_ready = 1'b1;
        idle(2);
        #1;
        check("rst_out_valid", int'(out_valid_a), 0);
        check("rst_out_sum", int'(out_sum_a), 0);
        check("rst_out_count", int'(out_count_a), 0);
        check("rst_out_ovf", int'(out_ovf_a), 0);
        check("rst_in_ready_low", int'(in_ready_a), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", int'(in_ready_a), 1);
        @(negedge clk);

        // Full group with one bubble of in_ready
        send(15, 0); send(12, 0); send(35, 0); send(49, 0);
        #1;
        check("full_out_valid", int'(out_valid_a), 1);
        lows = 0;
        for (int k = 0; k < 4; k++) begin
            if (!in_ready_a) lows++;
            @(negedge clk);
            #1;
        end
        check("full_ready_bubble", lows, 1);
        drain();

        // Early close and single-term group
        send(15, 0); send(12, 1); send(5, 1);
        drain();

        // Backpressure: held 7 becomes first term of the next group
        out_ready = 1'b0;
        repeat (4) send(10, 0);
        #1;
        snap = int'(out_sum_a);
        check("bp_sum_registered", snap, 40);
        fork
            send(7, 0);
            begin
                for (int k = 0; k < 5; k++) begin
                    #2;
                    check("bp_in_ready_low", int'(in_ready_a), 0);
                    check("bp_valid_held", int'(out_valid_a), 1);
                    check("bp_sum_stable", int'(out_sum_a), snap);
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
        join
        send(7, 0); send(7, 0); send(7, 0);
        drain();

        // Overflow on the 7-bit instance, then a clean group
        send(49, 0); send(49, 0); send(49, 0); send(1, 0);
        send(1, 0); send(1, 0); send(1, 0); send(1, 0);
        drain();

        // Reset mid-group
        send(20, 0); send(20, 0);
        do_reset();
        send(3, 0); send(3, 0); send(3, 0); send(3, 0);
        drain();

        // Reset while holding a result
        out_ready = 1'b0;
        send(9, 1);
        #1;
        check("done_valid_before_rst", int'(out_valid_a), 1);
        do_reset();
        #1;
        check("done_rst_clears_valid", int'(out_valid_a), 0);
        check("done_rst_clears_valid_b", int'(out_valid_b), 0);
        out_ready = 1'b1;
        @(negedge clk);

        // Gapped input
        send(10, 0); idle(2); send(10, 0); idle(1); send(10, 0); send(10, 0);
        drain();

        // Random groups, gaps, in_last and backpressure
        fork
            begin
                for (int g = 0; g < 150; g++) begin
                    send($urandom_range(0, 63), ($urandom_range(0, 5) == 0));
                    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                end
            end
            begin
                for (int c = 0; c < 900; c++) begin
                    out_ready = ($urandom_range(0, 2) != 0);
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
        join
        out_ready = 1'b1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
